pipe_ctrl: RTL

Pipeline control unit for the five-stage MIPS core. It arbitrates stall requests from IF, ID, EX and MEM into the `stall[5:0]` vector consumed by PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and turns MEM-stage exceptions into a pipeline flush with a redirect PC. It enforces a one-cycle refill window after every flush and runs a stall watchdog. Optional performance counters are included.

---
 rtl/pipe_ctrl_if.sv | 25 ++
 rtl/pipe_ctrl.sv | 96 +++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Stall/flush handshake bundle between the pipeline stages (master) and pipe_ctrl (slave).
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_timeout, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, stall_timeout, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall arbitration, exception flush/redirect, refill window and stall watchdog.
// Optional stall/flush performance counters are built when PIPE_PERF_EN is defined.
//
// state  | meaning
// RUN    | normal operation, MEM-stage exceptions are accepted
// REFILL | cycle after a flush, exceptions masked, stalls honoured
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter logic [7:0]  STALL_LIMIT = 8'd200
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {RUN = 1'b0, REFILL = 1'b1} state_t;

  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  state_t      state;
  logic        exc_take;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [7:0]  stall_run;
  logic [7:0]  stall_run_next;
  logic        stall_timeout;

  always_comb begin
    exc_take = (state == RUN) && (bus.excepttype_i != 32'd0) && !bus.stallreq_mem;
    flush    = exc_take;
    new_pc   = 32'd0;
    stall    = 6'b000000;
    if (exc_take) begin
      new_pc = (bus.excepttype_i == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
    end else if (bus.stallreq_mem) begin
      stall = 6'b011111;
    end else if (bus.stallreq_ex) begin
      stall = 6'b001111;
    end else if (bus.stallreq_id) begin
      stall = 6'b000111;
    end else if (bus.stallreq_if) begin
      stall = 6'b000011;
    end
  end

  // Saturate at the limit so a long stall cannot wrap the run length.
  assign stall_run_next = (stall_run >= STALL_LIMIT) ? STALL_LIMIT : stall_run + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      stall_run     <= 8'd0;
      stall_timeout <= 1'b0;
    end else begin
      case (state)
        RUN:     if (exc_take) state <= REFILL;
        REFILL:  state <= RUN;
        default: state <= RUN;
      endcase
      if (flush || (stall == 6'b000000)) begin
        stall_run <= 8'd0;
      end else begin
        stall_run <= stall_run_next;
        if (stall_run_next == STALL_LIMIT) stall_timeout <= 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 16'd0;
    end else begin
      if ((stall != 6'b000000) && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt;
  assign bus.flush_cnt_o = flush_cnt;
`else
  assign bus.stall_cnt_o = 32'd0;
  assign bus.flush_cnt_o = 16'd0;
`endif

  assign bus.stall         = stall;
  assign bus.flush         = flush;
  assign bus.new_pc        = new_pc;
  assign bus.stall_timeout = stall_timeout;

endmodule
